mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register outputs in the RV32I core.
//  - Turns mem_val/mem_rw/funct3 plus ALU address and RS2 data into a req/ack data-memory bus transaction.
//  - Aligns and extends load data; forwards WB controls to MEM/WB.
//  - Stalls the pipeline until the bus completes. An ack timeout aborts the transaction.
// PARAMETERS
//  ACK_TIMEOUT  16  max BUSY cycles waiting for dmem_ack before abort (>=1)
// PORTS
//  clk                    in   1   core clock, rising edge
//  rst                    in   1   asynchronous, active-low reset
//  alu_out_in             in   32  ALU result; byte address for memory ops
//  rs2_in                 in   32  store data
//  mem_val_in             in   1   1 = instruction is a load/store
//  mem_rw_in              in   1   1 = store, 0 = load
//  funct3_in              in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  wb_sel_in              in   2   writeback select, passed through
//  register_write_enable_in in 1   passed through (gated, see below)
//  rd_in                  in   5   destination register, passed through
//  dmem_req               out  1   bus request, held until ack or abort
//  dmem_we                out  1   1 = write
//  dmem_addr              out  32  word address {alu_out_in[31:2],2'b00}
//  dmem_wdata             out  32  lane-replicated store data
//  dmem_be                out  4   byte enables
//  dmem_ack               in   1   one-cycle completion strobe
//  dmem_rdata             in   32  read word, valid with dmem_ack
//  load_data_out          out  32  aligned/extended load result (registered)
//  alu_out_out            out  32  = alu_out_in (combinational)
//  wb_sel_out             out  2   = wb_sel_in
//  register_write_enable_out out 1 gated write enable
//  rd_out                 out  5   = rd_in
//  stall_out              out  1   1 = hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//  misalign_out           out  1   misaligned access flagged this cycle
//  bus_err_out            out  1   ack timeout on the access completing this cycle
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, timeout counter 0.
//  - Outputs at reset: dmem_req/dmem_we/dmem_be/dmem_addr/dmem_wdata = 0, load_data_out = 0, bus_err_out = 0.
//  Misaligned access: H with addr[0]=1, or W with addr[1:0]!=0.
//  - Outputs: misalign_out=1 and register_write_enable_out=0.
//  - No bus access; stall_out=0.
//  FSM states:
//  - IDLE: if mem_val_in & aligned:
//    - latch addr/we/be/wdata into bus regs; go BUSY.
//    - stall_out=1 (combinational).
//  - IDLE, otherwise: pass-through; stall_out=0.
//  - BUSY: dmem_req=1, stall_out=1, counter++ each cycle.
//    - On dmem_ack: capture extracted dmem_rdata into load_data_out; go RESP.
//    - If counter reaches ACK_TIMEOUT-1 without ack: drop req, load_data_out=0, bus_err=1; go RESP.
//  - RESP: dmem_req=0, stall_out=0 for exactly one cycle.
//    - This is the cycle MEM/WB captures the result.
//    - Next state IDLE unconditionally; the still-held inputs are not re-launched.
//    - bus_err_out reflects the abort.
//    - On error: register_write_enable_out=0.
//  - Ack latency is therefore ack_cycle+1. A zero-wait memory costs 2 stall cycles.
//  Store lanes:
//  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
//  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
//  - SW: be=4'b1111, wdata=rs2.
//  Load extract: w = dmem_rdata >> (8*addr[1:0]).
//  - B/H: sign-extend w[7:0]/w[15:0].
//  - BU/HU: zero-extend.
//  - W: w.
//  - Loads drive be=4'b1111.
//  Boundary cases:
//  - dmem_ack while IDLE or RESP: ignored.
//  - ack coincident with the timeout cycle: ack wins.
//  - Reset mid-BUSY: req drops immediately; a late ack is ignored.
//  - Counter clears on entry to BUSY.
// TESTING
//  - LW addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF.
//    -> req held 3 cycles, stall 4 cycles, RESP load_data_out=0xDEADBEEF.
//  - LB addr 0x103 rdata 0x80FF1234 -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
//  - SB addr 0x201 rs2=0x000000A5 -> be=0010, wdata=0xA5A5A5A5, we=1.
//  - SH addr 0x202 rs2=0x1234 -> be=1100, wdata=0x12341234.
//  - LW addr 0x102 -> misalign_out=1, no dmem_req, stall_out=0, register_write_enable_out=0.
//  - No ack for ACK_TIMEOUT cycles -> bus_err_out=1 in RESP, write enable 0, back to IDLE, req low.
//  - rst pulsed low mid-BUSY, then ack arrives -> dmem_req=0 at once, outputs at reset values, ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: launches req/ack bus transactions, aligns load data,
// and stalls the pipeline until the bus completes or times out.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] rs2_in,
  input  logic        mem_val_in,
  input  logic        mem_rw_in,
  input  logic [2:0]  funct3_in,
  input  logic [1:0]  wb_sel_in,
  input  logic        register_write_enable_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data_out,
  output logic [31:0] alu_out_out,
  output logic [1:0]  wb_sel_out,
  output logic        register_write_enable_out,
  output logic [4:0]  rd_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    offset_q;
  logic          err_q;
  logic          misalign;
  logic          launch;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off,
                                          input logic we);
    if (!we) return 4'b1111;
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign misalign = mem_val_in & is_misaligned(funct3_in, alu_out_in[1:0]);
  assign launch   = mem_val_in & ~misalign;

  assign dmem_req     = (state == BUSY);
  assign misalign_out = misalign;
  assign bus_err_out  = err_q;
  assign alu_out_out  = alu_out_in;
  assign wb_sel_out   = wb_sel_in;
  assign rd_out       = rd_in;
  assign register_write_enable_out = register_write_enable_in & ~misalign
                                     & ~((state == RESP) & err_q);

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = BUSY;
          stall_out = 1'b1;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (dmem_ack || (cnt == CNT_LAST)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus registers are latched at launch; the result is captured on ack (ack beats timeout).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      err_q         <= 1'b0;
      funct3_q      <= 3'd0;
      offset_q      <= 2'd0;
      dmem_we       <= 1'b0;
      dmem_be       <= 4'd0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      load_data_out <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (launch) begin
            cnt        <= '0;
            funct3_q   <= funct3_in;
            offset_q   <= alu_out_in[1:0];
            dmem_we    <= mem_rw_in;
            dmem_be    <= store_be(funct3_in, alu_out_in[1:0], mem_rw_in);
            dmem_addr  <= {alu_out_in[31:2], 2'b00};
            dmem_wdata <= mem_rw_in ? store_data(funct3_in, rs2_in) : 32'd0;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (dmem_ack) begin
            load_data_out <= load_extract(funct3_q, offset_q, dmem_rdata);
            err_q         <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            load_data_out <= 32'd0;
            err_q         <= 1'b1;
          end
        end
        RESP:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
